serial_adder_n: RTL and testbench

Parametrised bit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands one bit per clock through a single full-adder cell with a registered carry. A START/BUSY/DONE handshake frames each operation. The block is the sequential, width-generic successor of the gate-level half adder and serves as the area-minimal arithmetic unit for slow datapaths and lab designs.

---
 rtl/serial_adder_n.sv | 119 +++++++++++
 tb/tb_serial_adder_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Purpose : bit-serial WIDTH-bit adder/subtractor built on one full-adder cell with a registered carry.
// Latency : DONE is high in the cycle after edge t0+WIDTH, where t0 is the edge that accepts START. One result every WIDTH+1 cycles.
// Backpress: START is ignored while BUSY. START in the DONE cycle is accepted, so operations can run back-to-back.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse, sampled only when not busy
//   mode     0 = x+y, 1 = x-y (sampled with start)
//   x, y     operands (sampled with start)
//   busy     high while bits are being processed
//   done     one-cycle pulse when sum/carry/overflow have been written
//   sum      result modulo 2^WIDTH, held until the next completion
//   carry    carry out (add) / no-borrow, i.e. x>=y unsigned (sub)
//   overflow signed two's-complement overflow of the last result
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;

    logic             bit_s;
    logic             bit_cout;
    logic             last_bit;
    logic             accept;

    // Full-adder cell working on the LSBs of the operand shift registers.
    assign bit_s    = a_sr[0] ^ b_sr[0] ^ c_reg;
    assign bit_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_reg) | (b_sr[0] & c_reg);

    // This edge processes the MSB; c_reg currently holds the carry into the MSB.
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // A new operation is accepted from IDLE and from FIN alike.
    assign accept   = start && ((state == IDLE) || (state == FIN));

    assign busy = (state == RUN);
    assign done = (state == FIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_bit ? FIN : RUN;
            FIN:     state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is x + ~y + 1: invert y and seed the carry with 1.
            a_sr  <= x;
            b_sr  <= mode ? ~y : y;
            c_reg <= mode;
            cnt   <= '0;
        end else if (state == RUN) begin
            c_reg  <= bit_cout;
            res_sr <= {bit_s, res_sr[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                // Outputs are only ever loaded with a complete result.
                sum      <= {bit_s, res_sr[WIDTH-1:1]};
                carry    <= bit_cout;
                overflow <= c_reg ^ bit_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Purpose : self-checking bench for serial_adder_n at WIDTH = 8, 16 and 2.
// Latency : expects DONE in the cycle after edge t0+WIDTH and BUSY high for WIDTH cycles.
// Backpress: exercises START ignored while busy, back-to-back operation and reset abort.
module tb_serial_adder_n;

    logic clk;
    logic rst_n;

    logic        start8, mode8, busy8, done8, carry8, ovf8;
    logic [7:0]  x8, y8, sum8;
    logic        start16, mode16, busy16, done16, carry16, ovf16;
    logic [15:0] x16, y16, sum16;
    logic        start2, mode2, busy2, done2, carry2, ovf2;
    logic [1:0]  x2, y2, sum2;

    int checks;
    int errors;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
    );

    serial_adder_n #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .x(x16), .y(y16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16)
    );

    serial_adder_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .x(x2), .y(y2),
        .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input bit st, input bit m,
                          input logic [63:0] a, input logic [63:0] b);
        case (w)
            8:       begin start8  = st; mode8  = m; x8  = a[7:0];  y8  = b[7:0];  end
            16:      begin start16 = st; mode16 = m; x16 = a[15:0]; y16 = b[15:0]; end
            default: begin start2  = st; mode2  = m; x2  = a[1:0];  y2  = b[1:0];  end
        endcase
    endtask

    function automatic bit get_done(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done2;
        endcase
    endfunction

    function automatic bit get_busy(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [63:0] get_sum(input int w);
        case (w)
            8:       return 64'(sum8);
            16:      return 64'(sum16);
            default: return 64'(sum2);
        endcase
    endfunction

    function automatic bit get_carry(input int w);
        case (w)
            8:       return carry8;
            16:      return carry16;
            default: return carry2;
        endcase
    endfunction

    function automatic bit get_ovf(input int w);
        case (w)
            8:       return ovf8;
            16:      return ovf16;
            default: return ovf2;
        endcase
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed views.
    task automatic ref_calc(input int w, input bit m, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] s, output bit c, output bit o);
        longint unsigned mask;
        longint unsigned ua, ub;
        longint          sa, sb, r, hi, lo;
        mask = (64'd1 << w) - 1;
        ua   = a & mask;
        ub   = b & mask;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        sa   = (ua > longint'(hi)) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = (ub > longint'(hi)) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        if (m) begin
            s = (ua - ub) & mask;
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            s = (ua + ub) & mask;
            c = ((ua + ub) > mask);
            r = sa + sb;
        end
        o = (r > hi) || (r < lo);
    endtask

    // Issue one operation, optionally scrambling inputs after the START edge,
    // and wait (bounded) for DONE. lat counts cycles from the START edge.
    task automatic run_op(input int w, input bit m, input logic [63:0] a, input logic [63:0] b,
                          input bit scramble,
                          output logic [63:0] s, output bit c, output bit o,
                          output int lat, output int bcnt);
        set_in(w, 1'b1, m, a, b);
        tick();
        if (scramble)
            set_in(w, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        else
            set_in(w, 1'b0, m, a, b);
        lat  = 0;
        bcnt = 0;
        while (!get_done(w) && lat < 200) begin
            if (get_busy(w)) bcnt++;
            tick();
            lat++;
        end
        s = get_sum(w);
        c = get_carry(w);
        o = get_ovf(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(8, 1'b0, 1'b0, 64'd0, 64'd0);
        set_in(16, 1'b0, 1'b0, 64'd0, 64'd0);
        set_in(2, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        tick();
        checks++; if (sum8 !== 8'h00)  begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
        checks++; if (carry8 !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry8); end
        checks++; if (ovf8 !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", ovf8); end
        checks++; if (busy8 !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed(input string name, input bit m,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] es, input bit ec, input bit eo, input bit chk_o);
        logic [63:0] s;
        bit c, o;
        int lat, bcnt;
        run_op(8, m, 64'(a), 64'(b), 1'b0, s, c, o, lat, bcnt);
        checks++; if (lat !== 8)
            begin errors++; $display("FAIL %s_latency got %0d want 8", name, lat); end
        checks++; if (bcnt !== 8)
            begin errors++; $display("FAIL %s_busy_cycles got %0d want 8", name, bcnt); end
        checks++; if (s[7:0] !== es)
            begin errors++; $display("FAIL %s_sum got %h want %h", name, s[7:0], es); end
        checks++; if (c !== ec)
            begin errors++; $display("FAIL %s_carry got %b want %b", name, c, ec); end
        if (chk_o) begin
            checks++; if (o !== eo)
                begin errors++; $display("FAIL %s_ovf got %b want %b", name, o, eo); end
        end
        tick();
    endtask

    task automatic test_add();
        test_directed("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        test_directed("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
        test_directed("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_sub();
        test_directed("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1);
        test_directed("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1);
        test_directed("sub_3c_3c", 1'b1, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // START during RUN is ignored and inputs changing after the START edge have no effect.
    task automatic test_ignored_start();
        int lat;
        set_in(8, 1'b1, 1'b0, 64'h12, 64'h34);
        tick();
        set_in(8, 1'b0, 1'b1, 64'hFF, 64'hEE);
        tick();
        tick();
        set_in(8, 1'b1, 1'b0, 64'h00, 64'h00);
        tick();
        set_in(8, 1'b0, 1'b1, 64'h55, 64'hAA);
        lat = 3;
        while (!done8 && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 8)    begin errors++; $display("FAIL ign_latency got %0d want 8", lat); end
        checks++; if (sum8 !== 8'h46) begin errors++; $display("FAIL ign_sum got %h want 46", sum8); end
        checks++; if (carry8 !== 1'b0) begin errors++; $display("FAIL ign_carry got %b want 0", carry8); end
        tick();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL ign_done_after got %b want 0", done8); end
        tick();
    endtask

    // START held high: a new op starts in every DONE cycle, DONEs are WIDTH+1 apart.
    task automatic test_back_to_back();
        int cyc;
        int ndone;
        int dcyc[3];
        set_in(8, 1'b1, 1'b0, 64'h01, 64'h02);
        tick();
        cyc   = 1;
        ndone = 0;
        while (ndone < 3 && cyc < 100) begin
            if (done8) begin
                dcyc[ndone] = cyc;
                ndone++;
                checks++; if (sum8 !== 8'h03)
                    begin errors++; $display("FAIL b2b_sum%0d got %h want 03", ndone, sum8); end
                if (ndone == 3) set_in(8, 1'b0, 1'b0, 64'h01, 64'h02);
            end
            if (ndone < 3) begin
                tick();
                cyc++;
            end
        end
        checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", ndone); end
        if (ndone == 3) begin
            checks++; if (dcyc[1] - dcyc[0] !== 9)
                begin errors++; $display("FAIL b2b_gap1 got %0d want 9", dcyc[1] - dcyc[0]); end
            checks++; if (dcyc[2] - dcyc[1] !== 9)
                begin errors++; $display("FAIL b2b_gap2 got %0d want 9", dcyc[2] - dcyc[1]); end
        end
        tick();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy got %b want 0", busy8); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] s;
        bit c, o;
        int lat, bcnt, seen;
        set_in(8, 1'b1, 1'b0, 64'hA5, 64'h5A);
        tick();
        set_in(8, 1'b0, 1'b0, 64'hA5, 64'h5A);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (sum8 !== 8'h00)  begin errors++; $display("FAIL rst_mid_sum got %h want 00", sum8); end
        checks++; if (carry8 !== 1'b0) begin errors++; $display("FAIL rst_mid_carry got %b want 0", carry8); end
        checks++; if (busy8 !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy8); end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_nodone got %0d want 0", seen); end
        run_op(8, 1'b0, 64'h01, 64'h01, 1'b0, s, c, o, lat, bcnt);
        checks++; if (s[7:0] !== 8'h02) begin errors++; $display("FAIL rst_fresh_sum got %h want 02", s[7:0]); end
        tick();
    endtask

    task automatic test_random(input int w, input int n);
        logic [63:0] s, es, a, b, mask;
        bit c, o, ec, eo, m;
        int lat, bcnt;
        mask = (64'd1 << w) - 1;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom} & mask;
            b = {$urandom, $urandom} & mask;
            m = 1'($urandom);
            ref_calc(w, m, a, b, es, ec, eo);
            run_op(w, m, a, b, 1'b1, s, c, o, lat, bcnt);
            checks++; if (lat !== w)
                begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", w, lat, w); end
            checks++; if (s !== es)
                begin errors++; $display("FAIL rnd%0d_sum m=%b a=%h b=%h got %h want %h", w, m, a, b, s, es); end
            checks++; if (c !== ec)
                begin errors++; $display("FAIL rnd%0d_carry m=%b a=%h b=%h got %b want %b", w, m, a, b, c, ec); end
            checks++; if (o !== eo)
                begin errors++; $display("FAIL rnd%0d_ovf m=%b a=%h b=%h got %b want %b", w, m, a, b, o, eo); end
            if (lat >= 200) break;
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random(16, 1000);
        test_random(2, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
